alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 16-bit ALU between two requesters: port 0 (main datapath
//  execute stage) and port 1 (branch/address-generation unit). Requests use a
//  valid/ready handshake and are granted round-robin. The block drives the
//  ALU's ALU_Cnt/operand inputs from latched registers, waits ALU_LAT cycles,
//  and returns the result tagged with the requester id.
// PARAMETERS
//  DATA_W   16  operand/result width
//  CNT_W    4   ALU_Cnt width
//  ALU_LAT  1   cycles from ALU inputs driven to result sampled (legal 1..4)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  req0_valid   in   1       port 0 request
//  req0_ready   out  1       port 0 accepted (combinational, see IDLE)
//  req0_cnt     in   CNT_W   port 0 ALU_Cnt code
//  req0_a       in   DATA_W  port 0 operand A
//  req0_b       in   DATA_W  port 0 operand B
//  req1_valid   in   1       port 1 request
//  req1_ready   out  1       port 1 accepted
//  req1_cnt     in   CNT_W   port 1 ALU_Cnt code
//  req1_a       in   DATA_W  port 1 operand A
//  req1_b       in   DATA_W  port 1 operand B
//  alu_cnt      out  CNT_W   to ALU ALU_Cnt
//  alu_a        out  DATA_W  to ALU operand A
//  alu_b        out  DATA_W  to ALU operand B
//  alu_result   in   DATA_W  from ALU
//  alu_zero     in   1       from ALU zero flag
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       response consumed
//  rsp_id       out  1       requester of response (0/1)
//  rsp_data     out  DATA_W  captured alu_result
//  rsp_zero     out  1       captured alu_zero
//  rsp_err      out  1       request carried illegal code (> 4'b1000)
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=1 (port 0 wins first tie), all output
//    registers 0; rsp_valid=0, busy=0, alu_cnt/alu_a/alu_b=0.
//  - Reset mid-operation aborts the op; no response is ever issued for it.
//  - IDLE: grant = only valid port; both valid -> port != last_grant.
//    reqN_ready=1 only for granted port, only in IDLE. On valid&ready: latch
//    cnt/a/b/id, load counter=ALU_LAT, -> EXEC. Neither valid: stay IDLE.
//  - Illegal code (cnt > 4'b1000): latched cnt forced to 4'b0000, err=1,
//    op still executed and responded.
//  - EXEC: alu_cnt/a/b driven from latched regs, stable whole state.
//    Counter decrements each cycle; when counter==1 capture alu_result,
//    alu_zero into rsp_data/rsp_zero, -> RESP.
//  - RESP: rsp_valid=1 with rsp_id/data/zero/err held stable until
//    rsp_ready; on rsp_valid&rsp_ready: last_grant=rsp_id, rsp_valid=0 next
//    cycle, -> IDLE. No grant in the same cycle as response handshake.
//  - Latency: accept edge -> rsp_valid high after ALU_LAT+1 cycles;
//    max throughput one op per ALU_LAT+2 cycles.
//  - Inputs on non-granted port ignored; requester must hold valid/data
//    until ready (standard valid/ready; no drop permitted).
//  - alu_* outputs keep last op's values in IDLE/RESP (no glitch to 0).
// TESTING
//  1 Reset, req0 cnt=0000 a=16'h0005 b=16'h0003 -> rsp_valid after 2 cycles
//    (ALU_LAT=1), rsp_id=0, rsp_data=16'h0008, rsp_zero=0, rsp_err=0.
//  2 req0,req1 both held valid 4 ops -> grant order 0,1,0,1; each ready
//    pulse exactly 1 cycle; ids match.
//  3 req1 cnt=0001 a=b=16'h1234, rsp_ready low 5 cycles -> rsp fields stable,
//    data=0, zero=1; no new ready until handshake + 1 cycle.
//  4 req0 cnt=4'b1111 -> alu_cnt=0000, rsp_err=1, response still delivered.
//  5 rst asserted in EXEC -> next cycle busy=0, rsp_valid=0; no response;
//    subsequent tie granted to port 0.
//  6 ALU_LAT=3 build: accept -> rsp_valid after 4 cycles; alu_a/b stable
//    throughout EXEC.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between the execute stage (port 0)
// and the branch/AGU unit (port 1), returning each result tagged with its requester.
module alu_arbiter #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [CNT_W-1:0]  i_req0_cnt,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [CNT_W-1:0]  i_req1_cnt,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    output logic [CNT_W-1:0]  o_alu_cnt,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_zero,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_zero,
    output logic              o_rsp_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LEGAL_CNT = CNT_W'(8);
    // A latency below 1 would make the countdown wrap, so it is clamped.
    localparam logic [2:0]       LAT_LOAD      = (ALU_LAT < 1) ? 3'd1 : 3'(ALU_LAT);

    state_t            r_state;
    logic              r_last_grant;
    logic [2:0]        r_lat_cnt;
    logic              r_id;
    logic              r_err;

    logic              w_in_idle;
    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_illegal;
    logic [CNT_W-1:0]  w_sel_cnt;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;

    // Grant selection and request mux: a tie goes to the port that was not served last.
    always_comb begin
        w_in_idle   = (r_state == ST_IDLE);
        w_grant_vld = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (i_req1_valid) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
        if (w_grant_id) begin
            w_sel_cnt = i_req1_cnt;
            w_sel_a   = i_req1_a;
            w_sel_b   = i_req1_b;
        end else begin
            w_sel_cnt = i_req0_cnt;
            w_sel_a   = i_req0_a;
            w_sel_b   = i_req0_b;
        end
        w_illegal    = (w_sel_cnt > MAX_LEGAL_CNT);
        o_req0_ready = w_in_idle & w_grant_vld & ~w_grant_id;
        o_req1_ready = w_in_idle & w_grant_vld &  w_grant_id;
    end

    // Arbitration FSM: latch request, count ALU latency, hold response until consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_lat_cnt    <= 3'd0;
            r_id         <= 1'b0;
            r_err        <= 1'b0;
            o_alu_cnt    <= '0;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_zero   <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        // Illegal codes are run as code 0 so the requester still gets a reply.
                        o_alu_cnt <= w_illegal ? '0 : w_sel_cnt;
                        o_alu_a   <= w_sel_a;
                        o_alu_b   <= w_sel_b;
                        r_id      <= w_grant_id;
                        r_err     <= w_illegal;
                        r_lat_cnt <= LAT_LOAD;
                        r_state   <= ST_EXEC;
                        o_busy    <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (r_lat_cnt == 3'd1) begin
                        o_rsp_data  <= i_alu_result;
                        o_rsp_zero  <= i_alu_zero;
                        o_rsp_id    <= r_id;
                        o_rsp_err   <= r_err;
                        o_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_lat_cnt   <= r_lat_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid  <= 1'b0;
                        r_last_grant <= o_rsp_id;
                        r_state      <= ST_IDLE;
                        o_busy       <= 1'b0;
                    end else begin
                        o_rsp_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    o_rsp_valid <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one ALU_LAT=1 instance for the main scenarios
// and one ALU_LAT=3 instance for the long-latency case.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [3:0]  c0 = 4'd0, c1 = 4'd0;
    logic [15:0] a0 = 16'd0, b0 = 16'd0, a1 = 16'd0, b1 = 16'd0;
    logic        rr = 1'b0;
    logic        rdy0, rdy1, rv, rid, rz, rerr, busy;
    logic [3:0]  acnt;
    logic [15:0] aa, ab, ares, rdata;
    logic        az;

    logic        v0_3 = 1'b0, v1_3 = 1'b0, rr_3 = 1'b0;
    logic        rdy0_3, rdy1_3, rv_3, rid_3, rz_3, rerr_3, busy_3;
    logic [3:0]  acnt_3;
    logic [15:0] aa_3, ab_3, ares_3, rdata_3;
    logic        az_3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External ALU behaviour as seen by the arbiter.
    function automatic logic [15:0] alu_model(input logic [3:0] cnt, input logic [15:0] a, input logic [15:0] b);
        case (cnt)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return a;
            default: return 16'd0;
        endcase
    endfunction

    assign ares   = alu_model(acnt, aa, ab);
    assign az     = (ares == 16'd0);
    assign ares_3 = alu_model(acnt_3, aa_3, ab_3);
    assign az_3   = (ares_3 == 16'd0);

    alu_arbiter #(.DATA_W(16), .CNT_W(4), .ALU_LAT(1)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_cnt(c0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_cnt(c1), .i_req1_a(a1), .i_req1_b(b1),
        .o_alu_cnt(acnt), .o_alu_a(aa), .o_alu_b(ab), .i_alu_result(ares), .i_alu_zero(az),
        .o_rsp_valid(rv), .i_rsp_ready(rr), .o_rsp_id(rid), .o_rsp_data(rdata),
        .o_rsp_zero(rz), .o_rsp_err(rerr), .o_busy(busy)
    );

    alu_arbiter #(.DATA_W(16), .CNT_W(4), .ALU_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0_3), .o_req0_ready(rdy0_3), .i_req0_cnt(c0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_valid(v1_3), .o_req1_ready(rdy1_3), .i_req1_cnt(c1), .i_req1_a(a1), .i_req1_b(b1),
        .o_alu_cnt(acnt_3), .o_alu_a(aa_3), .o_alu_b(ab_3), .i_alu_result(ares_3), .i_alu_zero(az_3),
        .o_rsp_valid(rv_3), .i_rsp_ready(rr_3), .o_rsp_id(rid_3), .o_rsp_data(rdata_3),
        .o_rsp_zero(rz_3), .o_rsp_err(rerr_3), .o_busy(busy_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (rv !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rv); end
        n_vec++; if ({acnt, aa, ab} !== 36'd0) begin n_err++; $display("FAIL reset_alu_regs got %h exp 0", {acnt, aa, ab}); end
        n_vec++; if ({rdy0, rdy1} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b exp 00", {rdy0, rdy1}); end
        n_vec++; if ({rid, rdata, rz, rerr} !== 19'd0) begin n_err++; $display("FAIL reset_rsp_regs got %h exp 0", {rid, rdata, rz, rerr}); end
    endtask

    task automatic test_basic();
        v0 = 1'b1; c0 = 4'b0000; a0 = 16'h0005; b0 = 16'h0003; rr = 1'b0;
        #1;
        n_vec++; if ({rdy0, rdy1} !== 2'b10) begin n_err++; $display("FAIL basic_ready got %b exp 10", {rdy0, rdy1}); end
        tick();
        v0 = 1'b0;
        n_vec++; if (busy !== 1'b1 || rv !== 1'b0) begin n_err++; $display("FAIL basic_exec busy/rv got %b%b exp 10", busy, rv); end
        n_vec++; if ({acnt, aa, ab} !== {4'b0000, 16'h0005, 16'h0003}) begin n_err++; $display("FAIL basic_alu_drive got %h exp 0_0005_0003", {acnt, aa, ab}); end
        tick();
        n_vec++; if (rv !== 1'b1) begin n_err++; $display("FAIL basic_rsp_valid got %b exp 1", rv); end
        n_vec++; if ({rid, rdata, rz, rerr} !== {1'b0, 16'h0008, 1'b0, 1'b0}) begin n_err++; $display("FAIL basic_rsp got id=%b data=%h z=%b err=%b exp 0 0008 0 0", rid, rdata, rz, rerr); end
        rr = 1'b1;
        tick();
        rr = 1'b0;
        n_vec++; if (rv !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_after_hs rv/busy got %b%b exp 00", rv, busy); end
    endtask

    task automatic test_round_robin();
        logic exp_id;
        do_reset();
        v0 = 1'b1; c0 = 4'd0; a0 = 16'h0010; b0 = 16'h0001;
        v1 = 1'b1; c1 = 4'd1; a1 = 16'h0100; b1 = 16'h0001;
        rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            #1;
            n_vec++; if ({rdy0, rdy1} !== {~exp_id, exp_id}) begin n_err++; $display("FAIL rr_grant op%0d got %b exp %b", i, {rdy0, rdy1}, {~exp_id, exp_id}); end
            tick();
            n_vec++; if ({rdy0, rdy1} !== 2'b00) begin n_err++; $display("FAIL rr_ready_pulse op%0d got %b exp 00", i, {rdy0, rdy1}); end
            tick();
            n_vec++; if (rv !== 1'b1 || rid !== exp_id) begin n_err++; $display("FAIL rr_rsp op%0d got rv=%b id=%b exp 1 %b", i, rv, rid, exp_id); end
            n_vec++; if (rdata !== (exp_id ? 16'h00FF : 16'h0011)) begin n_err++; $display("FAIL rr_data op%0d got %h exp %h", i, rdata, exp_id ? 16'h00FF : 16'h0011); end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d;
        v1 = 1'b1; c1 = 4'b0001; a1 = 16'h1234; b1 = 16'h1234;
        #1;
        n_vec++; if ({rdy0, rdy1} !== 2'b01) begin n_err++; $display("FAIL bp_ready got %b exp 01", {rdy0, rdy1}); end
        tick();
        v1 = 1'b0;
        tick();
        v0 = 1'b1; c0 = 4'd0; a0 = 16'h0001; b0 = 16'h0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++; if ({rv, rid, rdata, rz, rerr} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}) begin n_err++; $display("FAIL bp_hold cyc%0d got rv=%b id=%b d=%h z=%b e=%b exp 1 1 0000 1 0", k, rv, rid, rdata, rz, rerr); end
            n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_no_grant cyc%0d got %b exp 0", k, rdy0); end
            tick();
        end
        rr = 1'b1;
        #1;
        n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_hs_cycle_ready got %b exp 0", rdy0); end
        tick();
        rr = 1'b0;
        #1;
        n_vec++; if (rv !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL bp_after_hs rv/rdy0 got %b%b exp 01", rv, rdy0); end
        tick();
        v0 = 1'b0;
        tick();
        exp_d = 16'h0002;
        n_vec++; if (rv !== 1'b1 || rid !== 1'b0 || rdata !== exp_d) begin n_err++; $display("FAIL bp_next_op got rv=%b id=%b d=%h exp 1 0 %h", rv, rid, rdata, exp_d); end
        rr = 1'b1;
        tick();
        rr = 1'b0;
    endtask

    task automatic test_illegal();
        v0 = 1'b1; c0 = 4'b1111; a0 = 16'h0007; b0 = 16'h0002;
        tick();
        v0 = 1'b0;
        n_vec++; if (acnt !== 4'b0000) begin n_err++; $display("FAIL ill_alu_cnt got %b exp 0000", acnt); end
        tick();
        n_vec++; if ({rv, rid, rdata, rerr} !== {1'b1, 1'b0, 16'h0009, 1'b1}) begin n_err++; $display("FAIL ill_rsp got rv=%b id=%b d=%h err=%b exp 1 0 0009 1", rv, rid, rdata, rerr); end
        rr = 1'b1;
        tick();
        rr = 1'b0;
        v0 = 1'b1; c0 = 4'b1000; a0 = 16'h00F0; b0 = 16'h0003;
        tick();
        v0 = 1'b0;
        n_vec++; if (acnt !== 4'b1000) begin n_err++; $display("FAIL edge_alu_cnt got %b exp 1000", acnt); end
        tick();
        n_vec++; if ({rv, rdata, rerr} !== {1'b1, 16'h00F0, 1'b0}) begin n_err++; $display("FAIL edge_rsp got rv=%b d=%h err=%b exp 1 00f0 0", rv, rdata, rerr); end
        rr = 1'b1;
        tick();
        rr = 1'b0;
    endtask

    task automatic test_reset_mid();
        v0 = 1'b1; c0 = 4'd0; a0 = 16'h0003; b0 = 16'h0004;
        v1 = 1'b1; c1 = 4'd0; a1 = 16'h0020; b1 = 16'h0001;
        #1;
        n_vec++; if ({rdy0, rdy1} !== 2'b01) begin n_err++; $display("FAIL rm_tie_before got %b exp 01", {rdy0, rdy1}); end
        tick();
        v0 = 1'b0; v1 = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_in_exec got %b exp 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0 || rv !== 1'b0 || aa !== 16'd0) begin n_err++; $display("FAIL rm_after_rst busy=%b rv=%b a=%h exp 0 0 0000", busy, rv, aa); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (rv !== 1'b0) begin n_err++; $display("FAIL rm_no_rsp cyc%0d got %b exp 0", k, rv); end
        end
        v0 = 1'b1; v1 = 1'b1;
        #1;
        n_vec++; if ({rdy0, rdy1} !== 2'b10) begin n_err++; $display("FAIL rm_tie_after got %b exp 10", {rdy0, rdy1}); end
        tick();
        v0 = 1'b0; v1 = 1'b0;
        tick();
        n_vec++; if ({rv, rid, rdata, rerr} !== {1'b1, 1'b0, 16'h0007, 1'b0}) begin n_err++; $display("FAIL rm_rsp got rv=%b id=%b d=%h err=%b exp 1 0 0007 0", rv, rid, rdata, rerr); end
        rr = 1'b1;
        tick();
        rr = 1'b0;
    endtask

    task automatic test_lat3();
        v0_3 = 1'b1; c0 = 4'd2; a0 = 16'hF0F0; b0 = 16'h0FF0;
        #1;
        n_vec++; if ({rdy0_3, rdy1_3} !== 2'b10) begin n_err++; $display("FAIL lat3_ready got %b exp 10", {rdy0_3, rdy1_3}); end
        tick();
        v0_3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (rv_3 !== 1'b0 || busy_3 !== 1'b1) begin n_err++; $display("FAIL lat3_wait cyc%0d rv=%b busy=%b exp 0 1", k, rv_3, busy_3); end
            n_vec++; if ({acnt_3, aa_3, ab_3} !== {4'd2, 16'hF0F0, 16'h0FF0}) begin n_err++; $display("FAIL lat3_stable cyc%0d got %h exp 2_f0f0_0ff0", k, {acnt_3, aa_3, ab_3}); end
            tick();
        end
        n_vec++; if ({rv_3, rid_3, rdata_3, rz_3, rerr_3} !== {1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0}) begin n_err++; $display("FAIL lat3_rsp got rv=%b id=%b d=%h z=%b e=%b exp 1 0 00f0 0 0", rv_3, rid_3, rdata_3, rz_3, rerr_3); end
        rr_3 = 1'b1;
        tick();
        rr_3 = 1'b0;
        n_vec++; if (rv_3 !== 1'b0 || busy_3 !== 1'b0) begin n_err++; $display("FAIL lat3_after_hs rv/busy got %b%b exp 00", rv_3, busy_3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
